// File: rtl/count_extender_pkg.sv
// Shared constants and snapshot state type for the counter extension slice.
package counter_pkg;
  localparam int unsigned SRC_W         = 4;
  localparam int unsigned EXT_W_DEFAULT = 4;

  typedef enum logic {
    SNAP_IDLE = 1'b0,
    SNAP_HOLD = 1'b1
  } snap_state_t;
endpackage

// File: rtl/count_extender_if.sv
// Request/acknowledge snapshot port between the extender and a slower reader.
interface count_extender_if #(
  parameter int unsigned TW = counter_pkg::SRC_W + counter_pkg::EXT_W_DEFAULT
);
  logic          snap_req;
  logic          snap_ack;
  logic [TW-1:0] snap;
  logic          snap_valid;

  modport master (output snap_req, snap_ack, input snap, snap_valid);
  modport slave  (input snap_req, snap_ack, output snap, snap_valid);
endinterface

// File: rtl/count_extender_snap.sv
// Snapshot holder: captures the post-edge count on request, holds it until acknowledged.
module snap_hold
  import counter_pkg::*;
#(
  parameter int unsigned TW = SRC_W + EXT_W_DEFAULT
) (
  input  logic          Ck,
  input  logic          reset,
  input  logic [TW-1:0] count,
  input  logic          snap_req,
  input  logic          snap_ack,
  output logic [TW-1:0] snap,
  output logic          snap_valid
);
  snap_state_t state, state_next;
  logic        capture;

  always_ff @(posedge Ck) begin
    if (reset) begin
      state <= SNAP_IDLE;
      snap  <= '0;
    end else begin
      state <= state_next;
      if (capture) snap <= count;
    end
  end

  // A request is only honoured in HOLD when the same cycle releases the old value.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      SNAP_IDLE: begin
        if (snap_req) begin
          capture    = 1'b1;
          state_next = SNAP_HOLD;
        end
      end
      SNAP_HOLD: begin
        if (snap_ack) begin
          if (snap_req) capture = 1'b1;
          else          state_next = SNAP_IDLE;
        end
      end
      default: state_next = SNAP_IDLE;
    endcase
  end

  always_comb begin
    snap_valid = (state == SNAP_HOLD);
  end
endmodule

// File: rtl/count_extender.sv
// Extends a 4-bit wrapping source count into a wider running total with threshold,
// step-error, overflow and snapshot support.
module count_extender
  import counter_pkg::*;
#(
  parameter  int unsigned EXT_W = EXT_W_DEFAULT,
  localparam int unsigned TW    = EXT_W + SRC_W
) (
  input  logic             Ck,
  input  logic             reset,
  input  logic             src_reset_,
  input  logic [SRC_W-1:0] q_in,
  input  logic             clr,
  input  logic [TW-1:0]    limit,
  output logic [TW-1:0]    count,
  output logic             hit,
  output logic             step_err,
  output logic             ovf,
  count_extender_if.slave  snap_if
);
  logic [SRC_W-1:0] q_reg, q_next, d;
  logic [EXT_W-1:0] upper, upper_next;
  logic             ovf_next, err_next, hit_next;
  logic [TW-1:0]    count_next;

  assign count = {upper, q_reg};

  // Source resets and clears rebaseline without a wrap check, so they never count as wraps.
  always_comb begin
    q_next     = q_in;
    upper_next = upper;
    ovf_next   = ovf;
    err_next   = step_err;
    d          = q_in - q_reg;
    hit_next   = 1'b0;
    if (clr || !src_reset_) begin
      upper_next = '0;
      if (clr) begin
        ovf_next = 1'b0;
        err_next = 1'b0;
      end
    end else begin
      if (q_in < q_reg) begin
        upper_next = upper + 1'b1;
        if (upper == '1) ovf_next = 1'b1;
      end
      if (d > 4'd1) err_next = 1'b1;
    end
    count_next = {upper_next, q_next};
    if (src_reset_ && !clr)
      hit_next = (count_next == limit) && (count != limit);
  end

  always_ff @(posedge Ck) begin
    if (reset) begin
      q_reg    <= '0;
      upper    <= '0;
      ovf      <= 1'b0;
      step_err <= 1'b0;
      hit      <= 1'b0;
    end else begin
      q_reg    <= q_next;
      upper    <= upper_next;
      ovf      <= ovf_next;
      step_err <= err_next;
      hit      <= hit_next;
    end
  end

  snap_hold #(.TW(TW)) u_snap (
    .Ck         (Ck),
    .reset      (reset),
    .count      (count_next),
    .snap_req   (snap_if.snap_req),
    .snap_ack   (snap_if.snap_ack),
    .snap       (snap_if.snap),
    .snap_valid (snap_if.snap_valid)
  );
endmodule

// File: tb/tb_count_extender.sv
// Directed-vector bench for count_extender with hand-computed expectations.
module tb_count_extender;
  logic       Ck = 1'b0;
  logic       reset, src_reset_, clr;
  logic [3:0] q_in;
  logic [7:0] limit;
  logic [7:0] count;
  logic       hit, step_err, ovf;
  int         n_checks = 0;
  int         n_errors = 0;

  count_extender_if #(.TW(8)) sif ();

  count_extender #(.EXT_W(4)) dut (
    .Ck         (Ck),
    .reset      (reset),
    .src_reset_ (src_reset_),
    .q_in       (q_in),
    .clr        (clr),
    .limit      (limit),
    .count      (count),
    .hit        (hit),
    .step_err   (step_err),
    .ovf        (ovf),
    .snap_if    (sif.slave)
  );

  always #5 Ck = ~Ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Ck);
    #1;
  endtask

  task automatic check_snap(input string tag, input int exp_snap, input int exp_valid);
    check({tag, "_snap"}, 32'(sif.snap), exp_snap);
    check({tag, "_valid"}, 32'(sif.snap_valid), exp_valid);
  endtask

  initial begin
    reset = 1'b1; src_reset_ = 1'b1; clr = 1'b0; q_in = 4'd0; limit = 8'd20;
    sif.snap_req = 1'b0; sif.snap_ack = 1'b0;
    tick(); tick();
    check("rst_count", 32'(count), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_err", 32'(step_err), 0);
    check_snap("rst", 0, 0);

    // Count 0..19 with latency 1 across the first wrap
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      q_in = 4'(i);
      tick();
      check("seq_count", 32'(count), i);
      check("seq_hit", 32'(hit), 0);
    end
    check("seq_err", 32'(step_err), 0);

    q_in = 4'd4; tick();
    check("lim_count", 32'(count), 20);
    check("lim_hit", 32'(hit), 1);
    q_in = 4'd5; tick();
    check("lim_hit_drop", 32'(hit), 0);
    limit = 8'd21; tick();
    check("lim_hold_count", 32'(count), 21);
    check("lim_no_retrig", 32'(hit), 0);
    limit = 8'd20;

    for (int c = 22; c < 256; c++) begin
      q_in = 4'(c);
      tick();
      check("run_hit", 32'(hit), 0);
    end
    check("top_count", 32'(count), 255);
    check("top_ovf", 32'(ovf), 0);
    q_in = 4'd0; tick();
    check("ovf_count", 32'(count), 0);
    check("ovf_set", 32'(ovf), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_ovf", 32'(ovf), 0);
    check("clr_count", 32'(count), 0);

    // Upstream reset at 37: rebaseline to 0, no wrap, no step error, hit suppressed
    for (int c = 1; c <= 37; c++) begin
      q_in = 4'(c);
      tick();
    end
    check("pre_sr_count", 32'(count), 37);
    src_reset_ = 1'b0; q_in = 4'd0; limit = 8'd0;
    tick();
    check("sr_hit_supp", 32'(hit), 0);
    tick();
    check("sr_count", 32'(count), 0);
    check("sr_ovf", 32'(ovf), 0);
    check("sr_err", 32'(step_err), 0);
    src_reset_ = 1'b1; limit = 8'd20; q_in = 4'd1; tick();
    check("sr_resume1", 32'(count), 1);
    q_in = 4'd2; tick();
    check("sr_resume2", 32'(count), 2);

    // Step errors
    for (int c = 3; c <= 5; c++) begin q_in = 4'(c); tick(); end
    check("pre_jump_err", 32'(step_err), 0);
    q_in = 4'd9; tick();
    check("jump_err", 32'(step_err), 1);
    check("jump_count", 32'(count), 9);
    q_in = 4'd10; tick();
    check("err_sticky", 32'(step_err), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("err_clr", 32'(step_err), 0);
    check("err_clr_count", 32'(count), 10);
    for (int c = 11; c <= 14; c++) begin q_in = 4'(c); tick(); end
    q_in = 4'd2; tick();
    check("wrapjump_err", 32'(step_err), 1);
    check("wrapjump_count", 32'(count), 18);
    q_in = 4'd0; clr = 1'b1; tick(); clr = 1'b0;
    check("clr2_count", 32'(count), 0);

    // Snapshot handshake
    for (int c = 1; c <= 12; c++) begin q_in = 4'(c); tick(); end
    check("snap_pre_count", 32'(count), 12);
    sif.snap_req = 1'b1; q_in = 4'd13; tick();
    check_snap("cap1", 13, 1);
    sif.snap_req = 1'b0; q_in = 4'd14; tick();
    check_snap("hold", 13, 1);
    sif.snap_req = 1'b1; q_in = 4'd15; tick();
    check_snap("req_ignored", 13, 1);
    sif.snap_req = 1'b0; sif.snap_ack = 1'b1; q_in = 4'd0; tick();
    check_snap("ack", 13, 0);
    q_in = 4'd1; tick();
    check_snap("ack_idle", 13, 0);
    sif.snap_ack = 1'b0; sif.snap_req = 1'b1; q_in = 4'd1; tick();
    check_snap("cap2", 17, 1);
    sif.snap_ack = 1'b1; q_in = 4'd2; tick();
    check_snap("reqack", 18, 1);
    sif.snap_req = 1'b0; sif.snap_ack = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;
    check_snap("clr_keep", 18, 1);
    check("clr3_count", 32'(count), 2);

    // Reach overflow with the snapshot still held, then reset
    for (int c = 3; c < 256; c++) begin q_in = 4'(c); tick(); end
    q_in = 4'd0; tick();
    check("pre_rst_ovf", 32'(ovf), 1);
    check("pre_rst_valid", 32'(sif.snap_valid), 1);
    q_in = 4'd1; reset = 1'b1; tick();
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_ovf", 32'(ovf), 0);
    check("mid_rst_err", 32'(step_err), 0);
    check("mid_rst_hit", 32'(hit), 0);
    check_snap("mid_rst", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
